ext_wb_arbiter: RTL and testbench

EXT_WB_ARBITER -- requirements
Module: ext_wb_arbiter

---
 rtl/ext_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_ext_wb_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_wb_arbiter.sv
// ext_wb_arbiter: round-robin arbiter sharing one external Wishbone slave among NUM_MASTERS tile masters.
// Optional slave watchdog enabled by defining EXT_WB_ARBITER_TIMEOUT_EN.
module ext_wb_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0]      m_cab_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS*DW-1:0]   m_dat_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic                        s_we_o,
  output logic                        s_cab_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic                        s_ack_i,
  input  logic                        s_rty_i,
  input  logic                        s_err_i,
  input  logic [DW-1:0]               s_dat_i
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [GW-1:0] gnt;
  logic [GW-1:0] last;
  logic [GW-1:0] sel;
  logic [GW-1:0] idx;
  logic          sel_vld;
  logic          active;
  logic          to_hit;

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("ext_wb_arbiter: TIMEOUT must be within 1..65535");
  end

  // Reset gates the slave path immediately so an aborted grant emits nothing.
  assign active = (state == GRANT) && !rst;

  // First requester after the last-served master, in rotating order.
  always_comb begin
    sel     = last;
    sel_vld = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      idx = GW'((32'(last) + i) % NUM_MASTERS);
      if (!sel_vld && m_cyc_i[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= GW'(NUM_MASTERS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            state <= GRANT;
            gnt   <= sel;
            last  <= sel;
          end
        end
        GRANT: begin
          if (!m_cyc_i[gnt]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency request mux from the granted master to the slave.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_cab_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    if (active) begin
      s_adr_o = m_adr_i[32'(gnt)*AW +: AW];
      s_dat_o = m_dat_i[32'(gnt)*DW +: DW];
      s_sel_o = m_sel_i[32'(gnt)*SW +: SW];
      s_cyc_o = m_cyc_i[gnt];
      s_stb_o = m_stb_i[gnt] & ~to_hit;
      s_we_o  = m_we_i[gnt];
      s_cab_o = m_cab_i[gnt];
      s_cti_o = m_cti_i[32'(gnt)*3 +: 3];
      s_bte_o = m_bte_i[32'(gnt)*2 +: 2];
    end
  end

  // Slave responses reach only the granted master.
  always_comb begin
    m_ack_o = '0;
    m_rty_o = '0;
    m_err_o = '0;
    m_dat_o = '0;
    if (active) begin
      m_ack_o[gnt]                 = s_ack_i;
      m_rty_o[gnt]                 = s_rty_i;
      m_err_o[gnt]                 = s_err_i | to_hit;
      m_dat_o[32'(gnt)*DW +: DW]   = s_dat_i;
    end
  end

`ifdef EXT_WB_ARBITER_TIMEOUT_EN
  logic [15:0] to_cnt;

  assign to_hit = active && (to_cnt == 16'(TIMEOUT));

  // Counts strobed cycles the slave leaves unanswered.
  always_ff @(posedge clk) begin
    if (rst || state != GRANT || to_hit || s_ack_i || s_rty_i || s_err_i) begin
      to_cnt <= '0;
    end else if (s_stb_o) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

endmodule

// File: tb/tb_ext_wb_arbiter.sv
// Scoreboard bench for ext_wb_arbiter: expected grants and acks are queued as stimulus is driven.
module tb_ext_wb_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 8;

  typedef struct {
    int           m;
    logic [DW-1:0] d;
  } exp_ack_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i, m_cab_i;
  logic [N*SW-1:0] m_sel_i;
  logic [N*3-1:0]  m_cti_i;
  logic [N*2-1:0]  m_bte_i;
  logic [N-1:0]    m_ack_o, m_rty_o, m_err_o;
  logic [N*DW-1:0] m_dat_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic            s_cyc_o, s_stb_o, s_we_o, s_cab_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic            s_ack_i, s_rty_i, s_err_i;
  logic [DW-1:0]   s_dat_i;

  int       checks = 0;
  int       passed = 0;
  int       gnt_q[$];
  exp_ack_t ack_q[$];
  logic     cyc_q = 1'b0;
  logic     to_test = 1'b0;
  logic     any_out;
  int       exp_m;
  exp_ack_t ea_mon;
  logic [N*DW-1:0] dat_oth;

  ext_wb_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_we_i(m_we_i), .m_cab_i(m_cab_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
    .m_bte_i(m_bte_i), .m_ack_o(m_ack_o), .m_rty_o(m_rty_o), .m_err_o(m_err_o),
    .m_dat_o(m_dat_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_cab_o(s_cab_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_ack_i(s_ack_i), .s_rty_i(s_rty_i),
    .s_err_i(s_err_i), .s_dat_i(s_dat_i)
  );

  always #5 clk = ~clk;

  assign any_out = |{m_ack_o, m_rty_o, m_err_o, m_dat_o, s_adr_o, s_dat_o, s_sel_o,
                     s_cyc_o, s_stb_o, s_we_o, s_cab_o, s_cti_o, s_bte_o};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [AW-1:0] base(input int i);
    return {4'(i + 1), 28'h0};
  endfunction

  task automatic set_m(input int i, input logic cyc, input logic [2:0] cti, input logic [AW-1:0] adr);
    m_cyc_i[2'(i)]        = cyc;
    m_stb_i[2'(i)]        = cyc;
    m_we_i[2'(i)]         = 1'b0;
    m_cab_i[2'(i)]        = 1'b0;
    m_cti_i[i*3 +: 3]     = cti;
    m_bte_i[i*2 +: 2]     = 2'b00;
    m_sel_i[i*SW +: SW]   = '1;
    m_adr_i[i*AW +: AW]   = adr;
    m_dat_i[i*DW +: DW]   = '0;
  endtask

  // Waits (bounded) for the slave strobe; reports how many negedges it took.
  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s_cyc_o && s_stb_o) && n < 50);
    if (!(s_cyc_o && s_stb_o)) check("grant_wait_expired", 64'(0), 64'(1));
  endtask

  // Single-beat transfer: grant, one slave ack with data, then master releases.
  task automatic serve(input int m, input logic [DW-1:0] d, output int waited);
    exp_ack_t ea;
    wait_grant(waited);
    ea.m = m;
    ea.d = d;
    ack_q.push_back(ea);
    @(posedge clk); #1;
    s_ack_i = 1'b1;
    s_dat_i = d;
    @(posedge clk); #1;
    s_ack_i = 1'b0;
    s_dat_i = '0;
    set_m(m, 1'b0, 3'b000, '0);
  endtask

  // Output monitor: grant order, ack routing and data steering.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_cyc_o && !cyc_q) begin
        if (gnt_q.size() == 0) check("gnt_unexpected", 64'(s_adr_o[31:28]), 64'(0));
        else begin
          exp_m = gnt_q.pop_front();
          check("gnt_order", 64'(s_adr_o[31:28]), 64'(exp_m + 1));
        end
      end
      if (m_ack_o != '0) begin
        check("ack_onehot", 64'($countones(m_ack_o)), 64'(1));
        if (ack_q.size() == 0) check("ack_unexpected", 64'(m_ack_o), 64'(0));
        else begin
          ea_mon = ack_q.pop_front();
          check("ack_master", 64'(m_ack_o), 64'(1) << ea_mon.m);
          check("ack_dat", 64'(m_dat_o[ea_mon.m*DW +: DW]), 64'(ea_mon.d));
          dat_oth = m_dat_o;
          dat_oth[ea_mon.m*DW +: DW] = '0;
          check("dat_others_zero", 64'(|dat_oth), 64'(0));
        end
      end
      if (!to_test && m_err_o != '0) check("err_spurious", 64'(m_err_o), 64'(0));
    end
    cyc_q = s_cyc_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    int n_err;
    int first;
    rst = 1'b1;
    m_adr_i = '0; m_dat_i = '0; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_cab_i = '0;
    m_sel_i = '0; m_cti_i = '0; m_bte_i = '0;
    s_ack_i = 1'b0; s_rty_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;

    // Reset: all outputs quiet during and one cycle after
    @(negedge clk);
    check("rst_outputs", 64'(any_out), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_outputs", 64'(any_out), 64'(0));

    // All four masters at once: strict order 0..3 with one idle bubble
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      set_m(i, 1'b1, 3'b000, base(i));
      gnt_q.push_back(i);
    end
    for (int i = 0; i < 4; i++) begin
      serve(i, 32'h1111_1111 * DW'(i + 1), w);
      check("gnt_latency", 64'(w), (i == 0) ? 64'(2) : 64'(3));
    end

    // Master 1 drops cyc before the arbitration edge; master 2 wins
    repeat (2) @(posedge clk);
    #1;
    set_m(1, 1'b1, 3'b000, base(1));
    set_m(2, 1'b1, 3'b000, base(2));
    gnt_q.push_back(2);
    @(negedge clk);
    set_m(1, 1'b0, 3'b000, '0);
    serve(2, 32'h2222_0001, w);
    check("drop_gnt_latency", 64'(w), 64'(1));

    // Master 2 four-beat burst while master 1 waits
    repeat (2) @(posedge clk);
    #1;
    set_m(2, 1'b1, 3'b010, base(2));
    gnt_q.push_back(2);
    gnt_q.push_back(1);
    wait_grant(w);
    for (int b = 0; b < 4; b++) begin
      exp_ack_t ea;
      @(posedge clk); #1;
      if (b == 0) set_m(1, 1'b1, 3'b000, base(1));
      set_m(2, 1'b1, (b == 3) ? 3'b111 : 3'b010, base(2) + AW'(4 * b));
      ea.m = 2;
      ea.d = 32'hB000_0000 + DW'(b);
      ack_q.push_back(ea);
      s_ack_i = 1'b1;
      s_dat_i = ea.d;
      @(negedge clk);
      check("burst_adr", 64'(s_adr_o), 64'(base(2) + AW'(4 * b)));
      check("burst_m1_noack", 64'(m_ack_o[1]), 64'(0));
    end
    @(posedge clk); #1;
    s_ack_i = 1'b0;
    s_dat_i = '0;
    set_m(2, 1'b0, 3'b000, '0);

    // Master 1 read returns DEADBEEF on its own slice
    serve(1, 32'hDEAD_BEEF, w);
    check("m1_after_burst_latency", 64'(w), 64'(3));

    // Reset mid-grant of master 3, then 0 and 3 compete
    repeat (2) @(posedge clk);
    #1;
    set_m(3, 1'b1, 3'b000, base(3));
    gnt_q.push_back(3);
    wait_grant(w);
    @(posedge clk); #1;
    rst = 1'b1;
    s_ack_i = 1'b1;
    @(negedge clk);
    check("rst_mid_cyc", 64'(s_cyc_o), 64'(0));
    check("rst_mid_ack", 64'(m_ack_o), 64'(0));
    check("rst_mid_outputs", 64'(any_out), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    s_ack_i = 1'b0;
    set_m(0, 1'b1, 3'b000, base(0));
    gnt_q.push_back(0);
    gnt_q.push_back(3);
    @(negedge clk);
    check("post_rst_mid_cyc", 64'(s_cyc_o), 64'(0));
    serve(0, 32'h0000_00A0, w);
    serve(3, 32'h0000_00A3, w);

    // Slave never answers
    repeat (2) @(posedge clk);
    #1;
    to_test = 1'b1;
    set_m(0, 1'b1, 3'b000, base(0));
    gnt_q.push_back(0);
    wait_grant(w);
    n_err = 0;
    first = -1;
`ifdef EXT_WB_ARBITER_TIMEOUT_EN
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (m_err_o != '0) begin
        n_err++;
        if (first < 0) first = k;
        check("to_err_target", 64'(m_err_o), 64'(1));
        check("to_stb_forced_low", 64'(s_stb_o), 64'(0));
      end
    end
    check("to_err_cycle", 64'(first), 64'(TO));
    check("to_err_pulses", 64'(n_err), 64'(1));
`else
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (m_err_o != '0) n_err++;
    end
    check("noto_err_pulses", 64'(n_err), 64'(0));
    check("noto_grant_held", 64'(s_cyc_o && s_stb_o), 64'(1));
`endif
    @(posedge clk); #1;
    set_m(0, 1'b0, 3'b000, '0);
    repeat (3) @(negedge clk);
    check("to_release_cyc", 64'(s_cyc_o), 64'(0));
    to_test = 1'b0;

    check("gnt_queue_drained", 64'(gnt_q.size()), 64'(0));
    check("ack_queue_drained", 64'(ack_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
